// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: sends COMMA bytes after reset until the
// receiver has had MIN_SYNC alignment bytes, then shifts offered bytes out MSB-first.
module paralelo_serial_tx #(
  parameter int unsigned MIN_SYNC = 4,
  parameter logic [7:0]  COMMA    = 8'hBC
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       load_ack,
  output logic       serial_out,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [7:0] next_byte;
  logic [3:0] sync_cnt, sync_cnt_nxt;
  logic       load;
  logic       accept;

  always_ff @(posedge clk_32f) begin
    if (!reset) state <= SYNC;
    else        state <= state_nxt;
  end

  // The load that completes sync still carries COMMA; data starts one byte later.
  always_comb begin
    load         = (bit_cnt == 3'd0);
    accept       = (state == ACTIVE) && valid_in;
    next_byte    = accept ? data_in : COMMA;
    state_nxt    = state;
    sync_cnt_nxt = sync_cnt;
    if (load && (state == SYNC)) begin
      sync_cnt_nxt = sync_cnt + 4'd1;
      if (sync_cnt == 4'(MIN_SYNC - 1)) state_nxt = ACTIVE;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      sync_cnt   <= '0;
      serial_out <= 1'b0;
      valid_out  <= 1'b0;
      load_ack   <= 1'b0;
      active     <= 1'b0;
    end else begin
      bit_cnt  <= bit_cnt + 3'd1;
      sync_cnt <= sync_cnt_nxt;
      active   <= (state_nxt == ACTIVE);
      if (load) begin
        serial_out <= next_byte[7];
        shift_reg  <= {next_byte[6:0], 1'b0};
        valid_out  <= accept;
        load_ack   <= accept;
      end else begin
        serial_out <= shift_reg[7];
        shift_reg  <= {shift_reg[6:0], 1'b0};
        load_ack   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx: default MIN_SYNC instance plus a MIN_SYNC=1 instance.
module tb_paralelo_serial_tx;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;

  logic load_ack0, serial_out0, valid_out0, active0;
  logic load_ack1, serial_out1, valid_out1, active1;

  int checks   = 0;
  int failures = 0;
  int cur_slot = 0;
  int cur_bit  = 0;

  always #5 clk_32f = ~clk_32f;

  paralelo_serial_tx dut0 (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .load_ack  (load_ack0),
    .serial_out(serial_out0),
    .valid_out (valid_out0),
    .active    (active0)
  );

  paralelo_serial_tx #(.MIN_SYNC(1), .COMMA(8'hBC)) dut1 (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .load_ack  (load_ack1),
    .serial_out(serial_out1),
    .valid_out (valid_out1),
    .active    (active1)
  );

  typedef struct {
    logic       vin;
    logic [7:0] din;
    logic [7:0] exp0;   // byte expected from default instance
    logic       ev0;
    logic       ea0;    // active level of default instance during this byte
    logic [7:0] exp1;   // byte expected from MIN_SYNC=1 instance
    logic       ev1;
  } vec_t;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s slot=%0d bit=%0d actual=%0b expected=%0b",
               name, cur_slot, cur_bit, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_32f);
    #1;
  endtask

  // One byte slot: present inputs ahead of the load edge, then check all 8 cycles.
  task automatic run_byte(input vec_t v, input logic chk1);
    valid_in = v.vin;
    data_in  = v.din;
    for (int k = 0; k < 8; k++) begin
      cur_bit = k;
      tick();
      chk("ser0",   serial_out0, v.exp0[7-k]);
      chk("vout0",  valid_out0,  v.ev0);
      chk("ack0",   load_ack0,   (k == 0) && v.ev0);
      chk("active0", active0,    v.ea0);
      if (chk1) begin
        chk("ser1",    serial_out1, v.exp1[7-k]);
        chk("vout1",   valid_out1,  v.ev1);
        chk("ack1",    load_ack1,   (k == 0) && v.ev1);
        chk("active1", active1,     1'b1);
      end
    end
  endtask

  vec_t vecs[11];
  vec_t tmp;

  initial begin
    // slots 0-3: data offered during sync is ignored by the default instance
    for (int s = 0; s < 4; s++)
      vecs[s] = '{1'b1, 8'hA5, 8'hBC, 1'b0, (s >= 3), (s == 0) ? 8'hBC : 8'hA5, (s != 0)};
    vecs[4]  = '{1'b1, 8'hA5, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1};
    vecs[5]  = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1};
    vecs[6]  = '{1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1};
    vecs[7]  = '{1'b1, 8'h5A, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1};
    vecs[8]  = '{1'b1, 8'h3C, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1};
    vecs[9]  = '{1'b0, 8'h77, 8'hBC, 1'b0, 1'b1, 8'hBC, 1'b0};
    vecs[10] = '{1'b1, 8'hBC, 8'hBC, 1'b1, 1'b1, 8'hBC, 1'b1};

    reset    = 1'b0;
    valid_in = 1'b1;
    data_in  = 8'hFF;
    cur_slot = -1;
    for (int i = 0; i < 3; i++) begin
      cur_bit = i;
      tick();
      chk("rst_ser",    serial_out0, 1'b0);
      chk("rst_vout",   valid_out0,  1'b0);
      chk("rst_ack",    load_ack0,   1'b0);
      chk("rst_active", active0,     1'b0);
      chk("rst_active1", active1,    1'b0);
    end
    reset = 1'b1;

    for (int s = 0; s < 11; s++) begin
      cur_slot = s;
      run_byte(vecs[s], 1'b1);
    end

    // Mid-byte reset during 0xC3: four bits go out, then reset lands at bit_cnt==4.
    cur_slot = 100;
    valid_in = 1'b1;
    data_in  = 8'hC3;
    tmp.exp0 = 8'hC3;
    for (int k = 0; k < 4; k++) begin
      cur_bit = k;
      tick();
      chk("mid_ser",  serial_out0, tmp.exp0[7-k]);
      chk("mid_vout", valid_out0,  1'b1);
    end
    reset = 1'b0;
    tick();
    chk("mrst_ser",    serial_out0, 1'b0);
    chk("mrst_vout",   valid_out0,  1'b0);
    chk("mrst_ack",    load_ack0,   1'b0);
    chk("mrst_active", active0,     1'b0);
    chk("mrst_active1", active1,    1'b0);
    reset = 1'b1;
    for (int s = 0; s < 5; s++) begin
      cur_slot = 200 + s;
      if (s < 4) tmp = '{1'b1, 8'hC3, 8'hBC, 1'b0, (s >= 3), 8'h00, 1'b0};
      else       tmp = '{1'b1, 8'hC3, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b0};
      run_byte(tmp, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/paralelo_serial_tx.md
# paralelo_serial_tx

Parallel-to-serial transmitter for the PCIe-style physical-layer link. It sits directly upstream of the serial-to-parallel receiver. It accepts one byte per 8 `clk_32f` cycles and shifts it out MSB-first on a single serial line, together with a per-byte valid qualifier. After reset it emits a run of comma bytes (0xBC) so the receiver can align and declare itself active. After that, it sends comma whenever no valid data is offered.

## Interface
- `MIN_SYNC`, default 4: number of comma bytes transmitted after reset before data is accepted; legal range 1..15.
- `COMMA`, default 8'hBC: idle/alignment byte.
- `clk_32f`  input  1: bit clock. All logic is on the rising edge.
- `reset`  input  1: synchronous, active-low. Reset is sampled on `clk_32f`.
- `data_in`  input  8: parallel byte offered by upstream.
- `valid_in`  input  1: `data_in` holds a real data byte.
- `load_ack`  output  1: one-cycle pulse; the offered byte was captured.
- `serial_out`  output  1: serial bit stream, MSB first.
- `valid_out`  output  1: the byte currently on `serial_out` is data, not comma.
- `active`  output  1: sync phase complete; data is accepted.

## Operation
- State register values are SYNC and ACTIVE.
- Internal registers:
  - `bit_cnt` is 3 bits. It increments every cycle while `reset`=1 and wraps 7→0.
  - `shift_reg` is 8 bits.
  - `sync_cnt` is 4 bits.
- On a load edge (the edge where `bit_cnt`==0 is sampled), `next_byte` is chosen as follows:
  - In SYNC: `COMMA`.
  - In ACTIVE with `valid_in`=1: `data_in`.
  - In ACTIVE with `valid_in`=0: `COMMA`.
- Load edge actions:
  - `serial_out` ← `next_byte`[7].
  - `shift_reg` ← {`next_byte`[6:0], 0}.
  - `valid_out` ← (ACTIVE && `valid_in`).
  - `load_ack` ← (ACTIVE && `valid_in`).
- Non-load edge actions:
  - `serial_out` ← `shift_reg`[7].
  - `shift_reg` ← `shift_reg` << 1.
  - `load_ack` ← 0.
  - `valid_out` holds.
- SYNC → ACTIVE transition:
  - At each load edge in SYNC, `sync_cnt` increments.
  - If `sync_cnt`==`MIN_SYNC`-1 at a load edge, state ← ACTIVE and `active` ← 1. That load still transmits `COMMA`.
  - Data is therefore first accepted on the next load edge, 8 cycles later.
- ACTIVE is absorbing. Only reset returns the block to SYNC.
- `data_in` equal to `COMMA` with `valid_in`=1 is transmitted as data with `valid_out`=1. It is not filtered.
- `data_in` and `valid_in` are ignored on non-load edges. Upstream must hold them stable across the load edge. Changing them mid-byte has no effect.

## Timing
- Reset values (edge with `reset`=0):
  - `serial_out`=0, `valid_out`=0, `load_ack`=0, `active`=0.
  - `bit_cnt`=0, `shift_reg`=0, `sync_cnt`=0, state=SYNC.
- The first edge with `reset`=1 is a load edge: `COMMA`[7]=1 appears on `serial_out`.
- Byte framing: bit k (k=0 is MSB) of a byte is on `serial_out` during the cycle following the edge where `bit_cnt`==k. Each byte occupies exactly 8 consecutive cycles with no gaps.
- Latency: `data_in` sampled at a load edge → its MSB appears on `serial_out` after that same edge (1 cycle). Its LSB appears 7 cycles later.
- `valid_out` changes only at load edges. It is aligned with the byte's MSB and covers all 8 bits.
- `load_ack` is high for exactly the one cycle after an accepting load edge. It is never high in SYNC.
- `active` rises at load edge number `MIN_SYNC` after reset release, i.e. after edge (`MIN_SYNC`-1)·8+1. Default: the 25th edge.
- The first data MSB appears at load edge `MIN_SYNC`+1. Default: the 33rd edge after reset release.
- Reset mid-byte: all registers take their reset values at that edge. The partial byte is discarded with no completion. Sync restarts from `sync_cnt`=0.
- Reset held for multiple cycles: outputs stay at reset values. `bit_cnt` does not advance.

## Test plan
- Reset release, `valid_in`=0 for 64 cycles:
  - `serial_out` repeats 1,0,1,1,1,1,0,0 (0xBC) eight times.
  - `valid_out`=0 throughout; `load_ack` is never asserted.
  - `active` rises after edge 25.
- Sync gating: `valid_in`=1, `data_in`=0xA5 held from reset release:
  - The first 4 bytes are 0xBC with `valid_out`=0.
  - The 5th byte is 1,0,1,0,0,1,0,1 with `valid_out`=1.
  - `load_ack` pulses once at edge 33.
- Back-to-back data in ACTIVE: bytes 0x00, 0xFF, 0x5A presented on consecutive load edges.
  - The serial stream reproduces them MSB-first with no gaps.
  - `load_ack` pulses every 8 cycles; `valid_out` stays high.
- Mixed traffic: bytes 0x3C (valid), idle, 0xBC (valid).
  - Stream is 0x3C/`valid_out`=1, 0xBC/`valid_out`=0, 0xBC/`valid_out`=1.
- Mid-byte reset: assert `reset`=0 for 1 cycle while `bit_cnt`=4 during data 0xC3.
  - `serial_out`=0, `valid_out`=0, `active`=0 at the next edge.
  - Then 4 comma bytes follow before data resumes.
- Parameter `MIN_SYNC`=1:
  - `active` rises at the first load edge.
  - Data is accepted at the second load edge (edge 9).
